// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-requester arbiter in front of a single-ported synchronous data memory.
//   An IDLE cycle grants one requester (combinational gnt plus the memory
//   strobe). The following RESP cycle returns that requester's response
//   (rvalid, rdata, err). Because of this, the block completes at most one
//   access every two cycles.
//   Addresses that fall outside [MemStart, MemStart+MemSize) do not access
//   the memory. They are answered with err=1 and rdata=0.
//
//   Configuration macro: DMEM_ARB_FAIR_EN
//     defined   -> round-robin; the pointer flips to the other port after
//                  every grant
//     undefined -> fixed priority; port 0 wins when both ports request
//
// Ports
//   clk, reset_n                 clock, async active-low reset
//   pN_req/we/addr/wdata         requester N request (N = 0,1)
//   pN_gnt                       grant pulse (same cycle as the request in IDLE)
//   pN_rvalid/rdata/err          response pulse, one cycle after the grant
//   mem_en/we/addr/wdata         memory strobe, region-relative byte address
//   mem_rdata                    memory read data, one cycle after mem_en
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter logic [31:0] MemStart  = 32'h0001_0000,
    parameter logic [31:0] MemSize   = 32'h0000_1000,
    localparam int         AddrWidth = $clog2(MemSize)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 p0_req,
    input  logic                 p0_we,
    input  logic [31:0]          p0_addr,
    input  logic [31:0]          p0_wdata,
    output logic                 p0_gnt,
    output logic                 p0_rvalid,
    output logic [31:0]          p0_rdata,
    output logic                 p0_err,
    input  logic                 p1_req,
    input  logic                 p1_we,
    input  logic [31:0]          p1_addr,
    input  logic [31:0]          p1_wdata,
    output logic                 p1_gnt,
    output logic                 p1_rvalid,
    output logic [31:0]          p1_rdata,
    output logic                 p1_err,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata
);

    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    state_t r_state, w_state_nxt;
    logic   r_win;      // port that owns the pending response
    logic   r_err;      // pending response is out of range
    logic   r_rd;       // pending response is an in-range read (returns mem_rdata)

    logic        w_any, w_win, w_we, w_in_range;
    logic [31:0] w_addr, w_wdata, w_off;
    logic [1:0]  w_gnt, w_rvalid, w_err;
    logic [1:0][31:0] w_rdata;

    assign w_any = p0_req | p1_req;

`ifdef DMEM_ARB_FAIR_EN
    logic r_ptr;        // port favoured when both request
    assign w_win = (p0_req & p1_req) ? r_ptr : ~p0_req;
`else
    assign w_win = ~p0_req;
`endif

    assign w_we    = w_win ? p1_we    : p0_we;
    assign w_addr  = w_win ? p1_addr  : p0_addr;
    assign w_wdata = w_win ? p1_wdata : p0_wdata;

    // Compare at 33 bits so that MemStart+MemSize cannot wrap.
    assign w_in_range = ({1'b0, w_addr} >= {1'b0, MemStart}) &&
                        ({1'b0, w_addr} <  ({1'b0, MemStart} + {1'b0, MemSize}));
    assign w_off      = w_addr - MemStart;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = '0;
        w_rvalid    = '0;
        w_err       = '0;
        w_rdata     = '0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt  = RESP;
                    w_gnt[w_win] = 1'b1;
                    if (w_in_range) begin
                        mem_en    = 1'b1;
                        mem_we    = w_we;
                        mem_addr  = w_off[AddrWidth-1:0];
                        mem_wdata = w_wdata;
                    end
                end
            end
            RESP: begin
                w_state_nxt     = IDLE;
                w_rvalid[r_win] = 1'b1;
                w_err[r_win]    = r_err;
                w_rdata[r_win]  = r_rd ? mem_rdata : 32'h0;
            end
            default: w_state_nxt = IDLE;
        endcase
        // The grant path is combinational from the req inputs. Gate it here
        // so that every output is quiet while reset is held.
        if (!reset_n) begin
            w_gnt     = '0;
            w_rvalid  = '0;
            w_err     = '0;
            w_rdata   = '0;
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    assign p0_gnt    = w_gnt[0];
    assign p1_gnt    = w_gnt[1];
    assign p0_rvalid = w_rvalid[0];
    assign p1_rvalid = w_rvalid[1];
    assign p0_err    = w_err[0];
    assign p1_err    = w_err[1];
    assign p0_rdata  = w_rdata[0];
    assign p1_rdata  = w_rdata[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_win   <= 1'b0;
            r_err   <= 1'b0;
            r_rd    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_any) begin
                r_win <= w_win;
                r_err <= ~w_in_range;
                r_rd  <= w_in_range & ~w_we;
            end
        end
    end

`ifdef DMEM_ARB_FAIR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_ptr <= 1'b0;
        else if (r_state == IDLE && w_any)
            r_ptr <= ~w_win;
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [31:0]   p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic          p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0]   p0_rdata, p1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural synchronous memory with word granularity.
    logic [31:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[4]    = 32'hDEAD_BEEF;   // byte offset 'h010
        mem_rdata = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[11:2]];
        end
    end

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic any_out();
        return |{p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err,
                 mem_en, mem_we, p0_rdata, p1_rdata};
    endfunction

    // Response monitor: pops the scoreboard each time a response appears.
    always @(negedge clk) begin
        #1;
        if (p0_rvalid || p1_rvalid) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_rvalid: got p0=%0b p1=%0b expected none",
                         p0_rvalid, p1_rvalid);
            end else begin
                mon_e = sb.pop_front();
                chk("rvalid_port", {62'h0, p1_rvalid, p0_rvalid}, mon_e.port ? 64'h2 : 64'h1);
                chk("rdata", mon_e.port ? p1_rdata : p0_rdata, {32'h0, mon_e.rdata});
                chk("err", mon_e.port ? p1_err : p0_err, {63'h0, mon_e.err});
                chk("other_port_quiet", mon_e.port ? {p0_err, p0_rdata} : {p1_err, p1_rdata}, 64'h0);
            end
        end
    end

    task automatic clr_req();
        p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
        p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
    endtask

    // Single-port access: grant and memory strobe are checked in the request
    // cycle, and the expected response goes to the scoreboard.
    task automatic do_req(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_in,
                          input logic [AW-1:0] exp_maddr, input logic [31:0] exp_rdata);
        exp_t e;
        @(negedge clk);
        if (port) begin p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wdata; end
        else      begin p0_req = 1; p0_we = we; p0_addr = addr; p0_wdata = wdata; end
        #2;
        chk("gnt", {62'h0, p1_gnt, p0_gnt}, port ? 64'h2 : 64'h1);
        chk("mem_en", {63'h0, mem_en}, {63'h0, exp_in});
        if (exp_in)
            chk("mem_bus", {19'h0, mem_we, mem_addr, mem_wdata}, {19'h0, we, exp_maddr, wdata});
        e.port  = port;
        e.err   = !exp_in;
        e.rdata = (exp_in && !we) ? exp_rdata : 32'h0;
        sb.push_back(e);
        @(negedge clk);
        clr_req();
    endtask

    logic [1:0] exp_g;
    exp_t       e_arb;

    initial begin
        reset_n = 0;
        clr_req();
        #2;
        chk("reset_outputs", {63'h0, any_out()}, 64'h0);
        p0_req = 1; p1_req = 1;
        #1;
        chk("reset_gates_gnt", {62'h0, p1_gnt, p0_gnt}, 64'h0);
        clr_req();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;

        // Both ports request continuously for 8 cycles (reads of 'h010).
        @(negedge clk);
        p0_req = 1; p1_req = 1;
        p0_addr = 32'h0001_0010; p1_addr = 32'h0001_0010;
        for (int c = 0; c < 8; c++) begin
            #2;
            if (c % 2 == 0) begin
`ifdef DMEM_ARB_FAIR_EN
                exp_g = ((c / 2) % 2 == 0) ? 2'b01 : 2'b10;
`else
                exp_g = 2'b01;
`endif
                e_arb.port  = exp_g[1];
                e_arb.err   = 1'b0;
                e_arb.rdata = 32'hDEAD_BEEF;
                sb.push_back(e_arb);
            end else begin
                exp_g = 2'b00;
            end
            chk("arb_gnt", {62'h0, p1_gnt, p0_gnt}, {62'h0, exp_g});
            @(negedge clk);
        end
        clr_req();

        // Directed single-port accesses.
        do_req(0, 0, 32'h0001_0010, 32'h0,         1, 12'h010, 32'hDEAD_BEEF);
        do_req(1, 1, 32'h0001_0FFC, 32'h1234_5678, 1, 12'hFFC, 32'h0);
        do_req(0, 0, 32'h0001_1000, 32'h0,         0, 12'h000, 32'h0);
        do_req(0, 0, 32'h0000_FFFC, 32'h0,         0, 12'h000, 32'h0);
        do_req(1, 0, 32'h0001_0FFC, 32'h0,         1, 12'hFFC, 32'h1234_5678);
        do_req(0, 1, 32'h0001_0000, 32'h0000_A5A5, 1, 12'h000, 32'h0);
        do_req(1, 0, 32'h0001_0000, 32'h0,         1, 12'h000, 32'h0000_A5A5);
        do_req(1, 0, 32'hFFFF_FFFC, 32'h0,         0, 12'h000, 32'h0);

        // Grant p1, then reset during RESP: the response must be dropped.
        @(negedge clk);
        p1_req = 1; p1_addr = 32'h0001_0010;
        #2;
        chk("rst_pre_gnt", {62'h0, p1_gnt, p0_gnt}, 64'h2);
        @(negedge clk);
        reset_n = 0;
        #2;
        chk("rst_in_resp_quiet", {63'h0, any_out()}, 64'h0);
        clr_req();
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        p0_req = 1; p1_req = 1;
        p0_addr = 32'h0001_0010; p1_addr = 32'h0001_0010;
        #2;
        chk("post_rst_gnt", {62'h0, p1_gnt, p0_gnt}, 64'h1);
        e_arb.port = 0; e_arb.err = 0; e_arb.rdata = 32'hDEAD_BEEF;
        sb.push_back(e_arb);
        @(negedge clk);
        clr_req();
        @(negedge clk);
        @(negedge clk);
        #3;
        chk("sb_drained", sb.size(), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MemStart, default 'h0001_0000, base byte address of the data memory region.
REQ-002 SHALL have parameter MemSize, default 'h0000_1000, region size in bytes; AddrWidth = $clog2(MemSize) is derived, not overridable.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports pN_req (N=0,1)  input  1  requester N access request, held until granted or withdrawn.
REQ-006 SHALL have ports pN_we  input  1  requester N write (1) / read (0).
REQ-007 SHALL have ports pN_addr  input  32  requester N byte address.
REQ-008 SHALL have ports pN_wdata  input  32  requester N write data.
REQ-009 SHALL have ports pN_gnt  output  1  one-cycle grant pulse to requester N.
REQ-010 SHALL have ports pN_rvalid  output  1  one-cycle response pulse to requester N.
REQ-011 SHALL have ports pN_rdata  output  32  read data, valid with pN_rvalid on reads.
REQ-012 SHALL have ports pN_err  output  1  out-of-range flag, valid with pN_rvalid.
REQ-013 SHALL have port mem_en  output  1  memory access strobe.
REQ-014 SHALL have port mem_we  output  1  memory write enable.
REQ-015 SHALL have port mem_addr  output  AddrWidth  region-relative byte address.
REQ-016 SHALL have port mem_wdata  output  32  memory write data.
REQ-017 SHALL have port mem_rdata  input  32  synchronous memory read data, valid one cycle after mem_en.

Function
REQ-018 SHALL implement FSM states IDLE and RESP.
REQ-019 In IDLE with any pN_req=1, SHALL select one winner, assert its pN_gnt combinationally that cycle, and transition to RESP.
REQ-020 In IDLE with no request, SHALL hold all outputs deasserted and remain in IDLE.
REQ-021 Address in range iff MemStart <= addr < MemStart+MemSize, compared at full 32 bits without overflow.
REQ-022 For an in-range grant, SHALL drive mem_en=1, mem_we=pN_we, mem_addr=(addr-MemStart)[AddrWidth-1:0], mem_wdata=pN_wdata in the grant cycle.
REQ-023 For an out-of-range grant, SHALL keep mem_en=0 and record the error for RESP.
REQ-024 In RESP, SHALL pulse winner pN_rvalid for exactly one cycle, pN_rdata=mem_rdata on in-range reads, else 0; pN_err=1 only if out of range; then return to IDLE.
REQ-025 SHALL grant no request in RESP; peak throughput is one access per two cycles.
REQ-026 Loser of a simultaneous request SHALL see no gnt and SHALL be serviced on the next IDLE if still requesting.
REQ-027 Requester withdrawing pN_req before gnt SHALL cause no access and no response.
REQ-028 Non-winner outputs SHALL be 0 at all times; at most one pN_gnt and one pN_rvalid per cycle.

Reset
REQ-029 reset_n=0 SHALL asynchronously force state IDLE, all pN_gnt/pN_rvalid/pN_err/mem_en/mem_we=0, pN_rdata=0, priority pointer to port 0.
REQ-030 Reset asserted in RESP SHALL drop the pending response; no rvalid after reset release.

Configuration
REQ-031 Macro DMEM_ARB_FAIR_EN defined: round-robin; after each grant, priority pointer moves to the other port; simultaneous requests alternate.
REQ-032 Macro DMEM_ARB_FAIR_EN undefined: fixed priority, port 0 always wins simultaneous requests; pointer logic absent.

Verification
REQ-033 p0 read 'h0001_0010, mem_rdata='hDEAD_BEEF -> p0_gnt cycle t with mem_addr='h010, mem_we=0; p0_rvalid t+1, p0_rdata='hDEAD_BEEF, p0_err=0.
REQ-034 p1 write 'h0001_0FFC data 'h1234_5678 -> mem_en=1, mem_we=1, mem_addr='hFFC, mem_wdata='h1234_5678; p1_rvalid next cycle, err=0.
REQ-035 p0 read 'h0001_1000 and 'h0000_FFFC -> mem_en stays 0; p0_rvalid with p0_err=1, p0_rdata=0 each.
REQ-036 Both ports request continuously for 8 cycles -> with DMEM_ARB_FAIR_EN grants p0,p1,p0,p1; without, p0 four times, p1 none.
REQ-037 Grant p1, assert reset_n=0 in RESP -> p1_rvalid never asserts; all outputs 0 immediately; next simultaneous request grants p0.
